mem_arbiter: RTL and testbench

//  Shares a single memory port between the core's instruction-fetch (imem) and

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction-fetch and data valid/ready interfaces.
// The grant is held until the slave completes, and imem waits at most STARVE_LIMIT dmem grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter bit DMEM_PRIORITY = 1'b1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    imem_valid_i,
  output logic                    imem_ready_o,
  input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
  input  logic [DATA_WIDTH-1:0]   imem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] imem_we_i,
  output logic [DATA_WIDTH-1:0]   imem_rdata_o,
  input  logic                    dmem_valid_i,
  output logic                    dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_we_i,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  // state  | meaning
  // IDLE   | no transaction held; owner is this cycle's combinational winner
  // LOCK_I | imem request issued, waiting for mem_ready_i
  // LOCK_D | dmem request issued, waiting for mem_ready_i
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic own_i, own_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!imem_valid_i)
        starve_cnt <= '0;
      else if (imem_ready_o)
        starve_cnt <= '0;
      else if (dmem_ready_o && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    own_i     = 1'b0;
    own_d     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (imem_valid_i && dmem_valid_i) begin
          // Starvation bound overrides the static tie-break.
          if (starve_cnt == LIMIT) own_i = 1'b1;
          else if (DMEM_PRIORITY)  own_d = 1'b1;
          else                     own_i = 1'b1;
        end else begin
          own_i = imem_valid_i;
          own_d = dmem_valid_i;
        end
        if (!mem_ready_i) begin
          if (own_i)      state_nxt = LOCK_I;
          else if (own_d) state_nxt = LOCK_D;
        end
      end
      LOCK_I: begin
        own_i = 1'b1;
        if (!imem_valid_i || mem_ready_i) state_nxt = IDLE;
      end
      LOCK_D: begin
        own_d = 1'b1;
        if (!dmem_valid_i || mem_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = '0;
    if (own_i) begin
      mem_valid_o = imem_valid_i;
      mem_addr_o  = imem_addr_i;
      mem_wdata_o = imem_wdata_i;
      mem_we_o    = imem_we_i;
    end else if (own_d) begin
      mem_valid_o = dmem_valid_i;
      mem_addr_o  = dmem_addr_i;
      mem_wdata_o = dmem_wdata_i;
      mem_we_o    = dmem_we_i;
    end
  end

  assign imem_ready_o = mem_ready_i & own_i & imem_valid_i;
  assign dmem_ready_o = mem_ready_i & own_d & dmem_valid_i;
  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-cycle vector table plus multi-cycle lock,
// starvation and reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid_i, imem_ready_o;
  logic [31:0] imem_addr_i, imem_wdata_i, imem_rdata_o;
  logic [3:0]  imem_we_i;
  logic        dmem_valid_i, dmem_ready_o;
  logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [3:0]  dmem_we_i;
  logic        mem_valid_o, mem_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_we_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] IWD = 32'h1111_0000;
  localparam logic [31:0] DWD = 32'hCAFE_0000;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o), .imem_addr_i(imem_addr_i),
    .imem_wdata_i(imem_wdata_i), .imem_we_i(imem_we_i), .imem_rdata_o(imem_rdata_o),
    .dmem_valid_i(dmem_valid_i), .dmem_ready_o(dmem_ready_o), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i), .dmem_rdata_o(dmem_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  typedef struct {
    logic        iv, dv, rdy;
    logic [31:0] iaddr, daddr, rdata;
    logic        ev;
    logic [31:0] eaddr, ewd;
    logic [3:0]  ewe;
    logic        eir, edr, ebusy;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic dv, input logic rdy,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] rd);
    imem_valid_i = iv;
    dmem_valid_i = dv;
    mem_ready_i  = rdy;
    imem_addr_i  = ia;
    dmem_addr_i  = da;
    mem_rdata_i  = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    imem_wdata_i = IWD;
    imem_we_i    = 4'h0;
    dmem_wdata_i = DWD;
    dmem_we_i    = 4'hF;
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;

    // Reset held for 3 cycles with valids low.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mem_valid", 32'(mem_valid_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_addr", mem_addr_o, 32'h0);
      chk("rst_readys", {30'h0, imem_ready_o, dmem_ready_o}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Single-cycle transactions from IDLE; starvation count evolves across rows 3..7.
    vt[0] = '{0,0,0, 32'h104, 32'h2004, 32'h01, 0, 32'h0,   32'h0, 4'h0, 0,0,0};
    vt[1] = '{1,0,1, 32'h104, 32'h2004, 32'hA1, 1, 32'h104, IWD,   4'h0, 1,0,0};
    vt[2] = '{0,1,1, 32'h104, 32'h2008, 32'hA2, 1, 32'h2008, DWD,  4'hF, 0,1,0};
    vt[3] = '{1,1,1, 32'h108, 32'h2010, 32'hA3, 1, 32'h2010, DWD,  4'hF, 0,1,0};
    vt[4] = '{1,1,1, 32'h108, 32'h2014, 32'hA4, 1, 32'h2014, DWD,  4'hF, 0,1,0};
    vt[5] = '{1,1,1, 32'h108, 32'h2018, 32'hA5, 1, 32'h2018, DWD,  4'hF, 0,1,0};
    vt[6] = '{1,1,1, 32'h108, 32'h201C, 32'hA6, 1, 32'h201C, DWD,  4'hF, 0,1,0};
    vt[7] = '{1,1,1, 32'h10C, 32'h2020, 32'hA7, 1, 32'h10C, IWD,   4'h0, 1,0,0};
    vt[8] = '{0,1,1, 32'h10C, 32'h2024, 32'hA8, 1, 32'h2024, DWD,  4'hF, 0,1,0};
    vt[9] = '{0,0,1, 32'h10C, 32'h2028, 32'hA9, 0, 32'h0,   32'h0, 4'h0, 0,0,0};

    for (int v = 0; v < 10; v++) begin
      drive(vt[v].iv, vt[v].dv, vt[v].rdy, vt[v].iaddr, vt[v].daddr, vt[v].rdata);
      @(negedge clk);
      chk($sformatf("v%0d_valid", v), 32'(mem_valid_o), 32'(vt[v].ev));
      chk($sformatf("v%0d_addr", v), mem_addr_o, vt[v].eaddr);
      chk($sformatf("v%0d_wdata", v), mem_wdata_o, vt[v].ewd);
      chk($sformatf("v%0d_we", v), 32'(mem_we_o), 32'(vt[v].ewe));
      chk($sformatf("v%0d_iready", v), 32'(imem_ready_o), 32'(vt[v].eir));
      chk($sformatf("v%0d_dready", v), 32'(dmem_ready_o), 32'(vt[v].edr));
      chk($sformatf("v%0d_busy", v), 32'(busy_o), 32'(vt[v].ebusy));
      chk($sformatf("v%0d_irdata", v), imem_rdata_o, vt[v].rdata);
      chk($sformatf("v%0d_drdata", v), dmem_rdata_o, vt[v].rdata);
      next_cycle();
    end

    // imem alone at 0x100, slave answers two cycles later.
    drive(1, 0, 0, 32'h100, 32'h0, 32'h0);
    @(negedge clk);
    chk("b_c0_valid", 32'(mem_valid_o), 32'h1);
    chk("b_c0_addr", mem_addr_o, 32'h100);
    chk("b_c0_busy", 32'(busy_o), 32'h0);
    chk("b_c0_iready", 32'(imem_ready_o), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("b_c1_busy", 32'(busy_o), 32'h1);
    chk("b_c1_iready", 32'(imem_ready_o), 32'h0);
    chk("b_c1_addr", mem_addr_o, 32'h100);
    next_cycle();
    drive(1, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    chk("b_c2_busy", 32'(busy_o), 32'h1);
    chk("b_c2_iready", 32'(imem_ready_o), 32'h1);
    chk("b_c2_rdata", imem_rdata_o, 32'hDEADBEEF);
    next_cycle();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b_c3_busy", 32'(busy_o), 32'h0);
    chk("b_c3_iready", 32'(imem_ready_o), 32'h0);
    next_cycle();

    // Tie with count 0: dmem first, imem the cycle after dmem completes.
    drive(1, 1, 0, 32'h100, 32'h2000, 32'h0);
    @(negedge clk);
    chk("c_tie_addr", mem_addr_o, 32'h2000);
    chk("c_tie_we", 32'(mem_we_o), 32'hF);
    next_cycle();
    drive(1, 1, 1, 32'h100, 32'h2000, 32'h55);
    @(negedge clk);
    chk("c_d_addr", mem_addr_o, 32'h2000);
    chk("c_d_dready", 32'(dmem_ready_o), 32'h1);
    chk("c_d_iready", 32'(imem_ready_o), 32'h0);
    next_cycle();
    drive(1, 0, 1, 32'h100, 32'h2000, 32'h66);
    @(negedge clk);
    chk("c_i_addr", mem_addr_o, 32'h100);
    chk("c_i_iready", 32'(imem_ready_o), 32'h1);
    chk("c_i_busy", 32'(busy_o), 32'h0);
    next_cycle();

    // Locked dmem is not preempted by a late imem request.
    drive(0, 1, 0, 32'h100, 32'h3000, 32'h0);
    next_cycle();
    drive(1, 1, 0, 32'h100, 32'h3000, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("d_hold%0d_addr", k), mem_addr_o, 32'h3000);
      chk($sformatf("d_hold%0d_busy", k), 32'(busy_o), 32'h1);
      chk($sformatf("d_hold%0d_iready", k), 32'(imem_ready_o), 32'h0);
      next_cycle();
    end
    drive(1, 1, 1, 32'h100, 32'h3000, 32'h77);
    @(negedge clk);
    chk("d_done_dready", 32'(dmem_ready_o), 32'h1);
    chk("d_done_iready", 32'(imem_ready_o), 32'h0);
    next_cycle();
    drive(1, 0, 1, 32'h100, 32'h3000, 32'h78);
    @(negedge clk);
    chk("d_after_iready", 32'(imem_ready_o), 32'h1);
    next_cycle();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    next_cycle();

    // Continuous contention: D,D,D,D,I repeating.
    drive(1, 1, 1, 32'h400, 32'h5000, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k % 5 == 4) begin
        chk($sformatf("e%0d_grant_i", k), 32'(imem_ready_o), 32'h1);
        chk($sformatf("e%0d_addr", k), mem_addr_o, 32'h400);
      end else begin
        chk($sformatf("e%0d_grant_d", k), 32'(dmem_ready_o), 32'h1);
        chk($sformatf("e%0d_addr", k), mem_addr_o, 32'h5000);
      end
      next_cycle();
    end
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    next_cycle();

    // Asynchronous reset while locked on imem.
    drive(1, 0, 0, 32'h600, 32'h7000, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("f_locked_busy", 32'(busy_o), 32'h1);
    @(posedge clk);
    #2;
    dmem_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("f_rst_busy", 32'(busy_o), 32'h0);
    chk("f_rst_valid", 32'(mem_valid_o), 32'h1);
    chk("f_rst_addr", mem_addr_o, 32'h7000);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("f_rst_idle_valid", 32'(mem_valid_o), 32'h0);
    chk("f_rst_idle_addr", mem_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    drive(0, 1, 1, 32'h0, 32'h7100, 32'h99);
    @(negedge clk);
    chk("f_fresh_addr", mem_addr_o, 32'h7100);
    chk("f_fresh_dready", 32'(dmem_ready_o), 32'h1);
    chk("f_fresh_rdata", dmem_rdata_o, 32'h99);
    next_cycle();
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("f_end_busy", 32'(busy_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
